// File: rtl/i2s_adc_receiver.sv
// I2S ADC receiver: synchronizes bclk/lrclk/dout, captures left-justified words, pairs left/right.
// out_stb rises 3 clk after the pair-closing bclk rise is sampled; a pair formed while un-acked is dropped (sticky overrun).
module i2s_adc_receiver #(
    parameter int SAMPLE_BITS = 24,
    parameter int SCLK_HALF   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bclk_in,
    input  logic                   lrclk_in,
    input  logic                   dout_in,
    output logic                   sclk_out,
    output logic [SAMPLE_BITS-1:0] left_out,
    output logic [SAMPLE_BITS-1:0] right_out,
    output logic                   out_stb,
    input  logic                   out_ack,
    output logic                   overrun_out
);

    localparam int CW = $clog2(SAMPLE_BITS + 1);
    localparam int DW = $clog2(SCLK_HALF + 1);
    localparam logic [CW-1:0]          CNT_FULL = CW'(SAMPLE_BITS);
    localparam logic [DW-1:0]          DIV_LAST = DW'(SCLK_HALF - 1);
    localparam logic [SAMPLE_BITS-1:0] MSB_MASK = {1'b1, {(SAMPLE_BITS-1){1'b0}}};

    logic [2:0]             bclk_q;
    logic [1:0]             lr_q;
    logic [1:0]             dout_q;
    logic [DW-1:0]          div_q, div_d;
    logic                   sclk_q, sclk_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SAMPLE_BITS-1:0] word_q, word_d;
    logic                   lr_prev_q, lr_prev_d;
    logic                   armed_q, armed_d;
    logic                   cls_vld_q, cls_vld_d;
    logic                   cls_right_q, cls_right_d;
    logic [SAMPLE_BITS-1:0] cls_word_q, cls_word_d;
    logic [SAMPLE_BITS-1:0] left_hold_q, left_hold_d;
    logic                   left_valid_q, left_valid_d;
    logic [SAMPLE_BITS-1:0] left_q, left_d;
    logic [SAMPLE_BITS-1:0] right_q, right_d;
    logic                   stb_q, stb_d;
    logic                   ovr_q, ovr_d;

    logic                   bclk_rise;
    logic                   pair_form;
    logic [SAMPLE_BITS-1:0] bit_mask;
    logic [SAMPLE_BITS-1:0] word_cap;

    always_comb begin
        bclk_rise    = bclk_q[1] & ~bclk_q[2];
        div_d        = div_q + 1'b1;
        sclk_d       = sclk_q;
        if (div_q == DIV_LAST) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
        end

        // Mask is zero once the word is full, so extra bits fall away naturally.
        bit_mask     = MSB_MASK >> cnt_q;
        word_cap     = dout_q[1] ? (word_q | bit_mask) : word_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        lr_prev_d    = lr_prev_q;
        armed_d      = armed_q;
        cls_vld_d    = 1'b0;
        cls_right_d  = cls_right_q;
        cls_word_d   = cls_word_q;
        if (bclk_rise) begin
            if (cnt_q != CNT_FULL) begin
                word_d = word_cap;
                cnt_d  = cnt_q + 1'b1;
            end
            if (lr_q[1] != lr_prev_q) begin
                cls_vld_d   = armed_q;
                cls_right_d = lr_prev_q;
                cls_word_d  = word_cap;
                cnt_d       = '0;
                word_d      = '0;
                lr_prev_d   = lr_q[1];
                armed_d     = 1'b1;
            end
        end

        pair_form    = cls_vld_q & cls_right_q & left_valid_q;
        left_hold_d  = left_hold_q;
        left_valid_d = left_valid_q;
        if (cls_vld_q && !cls_right_q) begin
            left_hold_d  = cls_word_q;
            left_valid_d = 1'b1;
        end
        if (pair_form) begin
            left_valid_d = 1'b0;
        end

        left_d       = left_q;
        right_d      = right_q;
        stb_d        = stb_q;
        ovr_d        = ovr_q;
        if (pair_form) begin
            if (!stb_q || out_ack) begin
                left_d  = left_hold_q;
                right_d = cls_word_q;
                stb_d   = 1'b1;
            end else begin
                ovr_d   = 1'b1;
            end
        end else if (stb_q && out_ack) begin
            stb_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_q       <= '0;
            lr_q         <= '0;
            dout_q       <= '0;
            div_q        <= '0;
            sclk_q       <= 1'b0;
            cnt_q        <= '0;
            word_q       <= '0;
            lr_prev_q    <= 1'b0;
            armed_q      <= 1'b0;
            cls_vld_q    <= 1'b0;
            cls_right_q  <= 1'b0;
            cls_word_q   <= '0;
            left_hold_q  <= '0;
            left_valid_q <= 1'b0;
            left_q       <= '0;
            right_q      <= '0;
            stb_q        <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            bclk_q       <= {bclk_q[1:0], bclk_in};
            lr_q         <= {lr_q[0], lrclk_in};
            dout_q       <= {dout_q[0], dout_in};
            div_q        <= div_d;
            sclk_q       <= sclk_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            lr_prev_q    <= lr_prev_d;
            armed_q      <= armed_d;
            cls_vld_q    <= cls_vld_d;
            cls_right_q  <= cls_right_d;
            cls_word_q   <= cls_word_d;
            left_hold_q  <= left_hold_d;
            left_valid_q <= left_valid_d;
            left_q       <= left_d;
            right_q      <= right_d;
            stb_q        <= stb_d;
            ovr_q        <= ovr_d;
        end
    end

    assign sclk_out    = sclk_q;
    assign left_out    = left_q;
    assign right_out   = right_q;
    assign out_stb     = stb_q;
    assign overrun_out = ovr_q;

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Directed bench for i2s_adc_receiver: I2S frames driven with a one-bclk data delay, clk = 8x bclk.
module tb_i2s_adc_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        bclk_in;
    logic        lrclk_in;
    logic        dout_in;
    logic        sclk_out;
    logic [23:0] left_out;
    logic [23:0] right_out;
    logic        out_stb;
    logic        out_ack;
    logic        overrun_out;

    int   n_checks = 0;
    int   n_errors = 0;
    logic d_prev   = 1'b0;

    i2s_adc_receiver #(.SAMPLE_BITS(24), .SCLK_HALF(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .bclk_in    (bclk_in),
        .lrclk_in   (lrclk_in),
        .dout_in    (dout_in),
        .sclk_out   (sclk_out),
        .left_out   (left_out),
        .right_out  (right_out),
        .out_stb    (out_stb),
        .out_ack    (out_ack),
        .overrun_out(overrun_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        bclk_in  = 1'b0;
        lrclk_in = 1'b0;
        dout_in  = 1'b0;
        out_ack  = 1'b0;
        d_prev   = 1'b0;
        repeat (3) @(negedge clk);
        rst      = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_bit(input logic lr, input logic d);
        bclk_in  = 1'b0;
        lrclk_in = lr;
        dout_in  = d;
        repeat (4) @(negedge clk);
        bclk_in  = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Data lags lrclk by one slot, as on a real I2S link.
    task automatic send_half(input logic lr, input logic [23:0] val, input int nbits, input int slots);
        logic dn;
        for (int k = 0; k < slots; k++) begin
            dn = 1'b0;
            if (k < nbits) dn = val[nbits-1-k];
            send_bit(lr, d_prev);
            d_prev = dn;
        end
    endtask

    // Closing bclk rise lands on a negedge; returns at the negedge after edge N+2.
    task automatic rise_close();
        bclk_in  = 1'b0;
        lrclk_in = 1'b0;
        dout_in  = d_prev;
        d_prev   = 1'b0;
        repeat (4) @(negedge clk);
        bclk_in  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic arm(input int slots);
        send_half(1'b0, 24'h0, 0, 2);
        send_half(1'b1, 24'h0, 0, slots);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bclk_in = 1'b0; lrclk_in = 1'b0; dout_in = 1'b0; out_ack = 1'b0;

        // Reset state and sclk divider
        do_reset();
        chk("rst_stb",   out_stb,     0);
        chk("rst_ovr",   overrun_out, 0);
        chk("rst_left",  left_out,    0);
        chk("rst_right", right_out,   0);
        chk("rst_sclk",  sclk_out,    0);
        cyc(2); chk("sclk_c2", sclk_out, 0);
        cyc(1); chk("sclk_c3", sclk_out, 1);
        cyc(2); chk("sclk_c5", sclk_out, 1);
        cyc(1); chk("sclk_c6", sclk_out, 0);
        cyc(3); chk("sclk_c9", sclk_out, 1);

        // Basic pair with latency check
        do_reset();
        send_half(1'b0, 24'h0, 0, 4);
        send_half(1'b1, 24'hFFFFFF, 24, 32);
        send_half(1'b0, 24'h123456, 24, 32);
        send_half(1'b1, 24'hFEDCBA, 24, 32);
        chk("t1_pre_close", out_stb, 0);
        rise_close();
        chk("t1_lat_n2", out_stb, 0);
        @(negedge clk);
        chk("t1_lat_n3", out_stb,     1);
        chk("t1_left",   left_out,    32'h123456);
        chk("t1_right",  right_out,   32'hFEDCBA);
        chk("t1_ovr",    overrun_out, 0);
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        chk("t1_ack_clr", out_stb, 0);

        // Stream starts mid-right-word
        do_reset();
        send_half(1'b1, 24'hAAAAAA, 24, 12);
        send_half(1'b0, 24'h0F0F0F, 24, 32);
        send_half(1'b1, 24'h5A5A5A, 24, 32);
        chk("t2_no_partial", out_stb, 0);
        rise_close();
        @(negedge clk);
        chk("t2_stb",   out_stb,   1);
        chk("t2_left",  left_out,  32'h0F0F0F);
        chk("t2_right", right_out, 32'h5A5A5A);

        // Overrun: two pairs, no ack
        do_reset();
        arm(32);
        send_half(1'b0, 24'h111111, 24, 32);
        send_half(1'b1, 24'h222222, 24, 32);
        send_half(1'b0, 24'h333333, 24, 32);
        chk("t3_p1_left", left_out, 32'h111111);
        send_half(1'b1, 24'h444444, 24, 32);
        rise_close();
        @(negedge clk);
        chk("t3_stb",   out_stb,     1);
        chk("t3_left",  left_out,    32'h111111);
        chk("t3_right", right_out,   32'h222222);
        chk("t3_ovr",   overrun_out, 1);
        do_reset();
        chk("t3_ovr_rst", overrun_out, 0);

        // Ack coincides with new pair formation
        arm(32);
        send_half(1'b0, 24'hC0FFEE, 24, 32);
        send_half(1'b1, 24'hBEEF01, 24, 32);
        send_half(1'b0, 24'h765432, 24, 32);
        chk("t4_p1_stb",  out_stb,  1);
        chk("t4_p1_left", left_out, 32'hC0FFEE);
        send_half(1'b1, 24'h89ABCD, 24, 32);
        rise_close();
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        chk("t4_stb",   out_stb,     1);
        chk("t4_left",  left_out,    32'h765432);
        chk("t4_right", right_out,   32'h89ABCD);
        chk("t4_ovr",   overrun_out, 0);
        @(negedge clk);
        chk("t4_stb_hold", out_stb, 1);

        // 16-bit words in a 32-bclk frame
        do_reset();
        arm(16);
        send_half(1'b0, 24'h00ABCD, 16, 16);
        send_half(1'b1, 24'h001234, 16, 16);
        rise_close();
        @(negedge clk);
        chk("t5_stb",   out_stb,   1);
        chk("t5_left",  left_out,  32'hABCD00);
        chk("t5_right", right_out, 32'h123400);

        // Reset mid-word, then re-arm
        send_half(1'b0, 24'h999999, 24, 10);
        do_reset();
        chk("t6_stb",   out_stb,   0);
        chk("t6_left",  left_out,  0);
        chk("t6_right", right_out, 0);
        send_half(1'b1, 24'h333333, 24, 20);
        send_half(1'b0, 24'h444444, 24, 32);
        chk("t6_no_pair", out_stb, 0);
        send_half(1'b1, 24'h555555, 24, 32);
        rise_close();
        @(negedge clk);
        chk("t6_pair_stb",   out_stb,   1);
        chk("t6_pair_left",  left_out,  32'h444444);
        chk("t6_pair_right", right_out, 32'h555555);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
